// File: rtl/fp_pkg.sv
// Shared floating-point package: field widths, IEEE constants, divider FSM
// state encoding and operand classification.
// Optional feature macro: FP_DIV_SPECIAL_EN adds the SPECIAL divider state.
package fp_pkg;

    localparam int E_WIDTH = 8;
    localparam int F_WIDTH = 23;
    localparam int E_BIAS  = 127;

    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

`ifdef FP_DIV_SPECIAL_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_NORM    = 2'd2,
        ST_SPECIAL = 2'd3
    } fp_div_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_NORM    = 2'd2
    } fp_div_state_t;
`endif

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    // Denormals are flushed: a zero exponent is treated as a zero operand.
    function automatic fp_class_t fp_classify(input logic [E_WIDTH-1:0] exp_v,
                                              input logic [F_WIDTH-1:0] frac_v);
        fp_class_t cls_v;
        if (exp_v == {E_WIDTH{1'b0}}) begin
            cls_v = CLS_ZERO;
        end else if (exp_v == {E_WIDTH{1'b1}}) begin
            if (frac_v == {F_WIDTH{1'b0}}) begin
                cls_v = CLS_INF;
            end else begin
                cls_v = CLS_NAN;
            end
        end else begin
            cls_v = CLS_NORM;
        end
        return cls_v;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational back end shared by the FP divider and multiplier:
// normalize select on the raw quotient, half-up round, exponent adjust,
// range check and IEEE pack.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int E_WIDTH = fp_pkg::E_WIDTH,
    parameter int F_WIDTH = fp_pkg::F_WIDTH,
    parameter int E_BIAS  = fp_pkg::E_BIAS
) (
    input  logic [F_WIDTH+2:0]       q_i,
    input  logic                     sign_i,
    input  logic [E_WIDTH-1:0]       e1_i,
    input  logic [E_WIDTH-1:0]       e2_i,
    output logic [E_WIDTH+F_WIDTH:0] out_o,
    output logic                     uf_o
);

    // Exponent arithmetic needs one sign bit plus one bit of headroom.
    localparam int EXW = E_WIDTH + 2;
    localparam logic signed [EXW-1:0] E_MAX  = EXW'((1 << E_WIDTH) - 1);
    localparam logic signed [EXW-1:0] E_ZERO = {EXW{1'b0}};

    logic [F_WIDTH-1:0]      mant_s;
    logic                    rbit_s;
    logic signed [EXW-1:0]   adj_s;
    logic [F_WIDTH:0]        sum_s;
    logic [F_WIDTH-1:0]      mant_rnd_s;
    logic signed [EXW-1:0]   exp_s;

    // Normalize, round half-up, then range-check the biased exponent.
    always_comb begin
        mant_s     = {F_WIDTH{1'b0}};
        rbit_s     = 1'b0;
        adj_s      = E_ZERO;
        sum_s      = {(F_WIDTH+1){1'b0}};
        mant_rnd_s = {F_WIDTH{1'b0}};
        exp_s      = E_ZERO;
        out_o      = {(E_WIDTH+F_WIDTH+1){1'b0}};
        uf_o       = 1'b0;

        // Quotient lies in (0.5, 2): bit F+2 set means the ratio is >= 1.
        if (q_i[F_WIDTH+2]) begin
            mant_s = q_i[F_WIDTH+1:2];
            rbit_s = q_i[1];
            adj_s  = E_ZERO;
        end else begin
            mant_s = q_i[F_WIDTH:1];
            rbit_s = q_i[0];
            adj_s  = {EXW{1'b1}};
        end

        sum_s = {1'b0, mant_s} + {{F_WIDTH{1'b0}}, rbit_s};
        if (sum_s[F_WIDTH]) begin
            mant_rnd_s = {F_WIDTH{1'b0}};
            adj_s      = adj_s + EXW'(1);
        end else begin
            mant_rnd_s = sum_s[F_WIDTH-1:0];
        end

        exp_s = $signed({2'b00, e1_i}) - $signed({2'b00, e2_i})
              + $signed(EXW'(E_BIAS)) + adj_s;

        if (exp_s >= E_MAX) begin
            out_o = {sign_i, {E_WIDTH{1'b1}}, {F_WIDTH{1'b0}}};
            uf_o  = 1'b1;
        end else if (exp_s <= E_ZERO) begin
            out_o = {sign_i, {(E_WIDTH+F_WIDTH){1'b0}}};
            uf_o  = 1'b1;
        end else begin
            out_o = {sign_i, exp_s[E_WIDTH-1:0], mant_rnd_s};
            uf_o  = 1'b0;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: out = para1 / para2.
// Restoring radix-2 significand division, one quotient bit per clock,
// followed by one normalize/round/pack cycle (27-clock latency).
// Optional feature macro: FP_DIV_SPECIAL_EN classifies zero/inf/NaN operands
// in IDLE and answers them through a 1-clock SPECIAL state.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int E_WIDTH = fp_pkg::E_WIDTH,
    parameter int F_WIDTH = fp_pkg::F_WIDTH,
    parameter int E_BIAS  = fp_pkg::E_BIAS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [E_WIDTH+F_WIDTH:0] para1,
    input  logic [E_WIDTH+F_WIDTH:0] para2,
    output logic                     busy,
    output logic                     done,
    output logic [E_WIDTH+F_WIDTH:0] out,
    output logic                     under_overflow
);

    localparam int W   = E_WIDTH + F_WIDTH + 1;
    localparam int RW  = F_WIDTH + 2;   // partial remainder
    localparam int DW  = F_WIDTH + 1;   // divisor significand
    localparam int QW  = F_WIDTH + 3;   // quotient, also the iteration count
    localparam int CW  = $clog2(QW + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

    fp_div_state_t        state_q, state_d;
    logic                 sign_q, sign_d;
    logic [E_WIDTH-1:0]   e1_q, e1_d;
    logic [E_WIDTH-1:0]   e2_q, e2_d;
    logic [RW-1:0]        r_q, r_d;
    logic [DW-1:0]        d_q, d_d;
    logic [QW-1:0]        q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         out_q, out_d;
    logic                 uf_q, uf_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 ge_s;
    logic [RW-1:0]        r_sub_s;
    logic [W-1:0]         pack_out_s;
    logic                 pack_uf_s;

    // One restoring step: subtract the divisor when it fits.
    always_comb begin
        ge_s    = (r_q >= {1'b0, d_q});
        r_sub_s = r_q;
        if (ge_s) begin
            r_sub_s = r_q - {1'b0, d_q};
        end else begin
            r_sub_s = r_q;
        end
    end

    fp_round_pack #(
        .E_WIDTH (E_WIDTH),
        .F_WIDTH (F_WIDTH),
        .E_BIAS  (E_BIAS)
    ) u_round_pack (
        .q_i    (q_q),
        .sign_i (sign_q),
        .e1_i   (e1_q),
        .e2_i   (e2_q),
        .out_o  (pack_out_s),
        .uf_o   (pack_uf_s)
    );

`ifdef FP_DIV_SPECIAL_EN
    fp_class_t            cls_a_s, cls_b_s;
    logic                 spec_hit_s;
    logic [W-1:0]         spec_out_s;
    logic                 spec_uf_s;
    logic                 spec_sign_s;
    logic [W-1:0]         spec_out_q, spec_out_d;
    logic                 spec_uf_q, spec_uf_d;

    // Decide whether the incoming operands bypass the iterative divider.
    always_comb begin
        cls_a_s     = fp_classify(para1[W-2:F_WIDTH], para1[F_WIDTH-1:0]);
        cls_b_s     = fp_classify(para2[W-2:F_WIDTH], para2[F_WIDTH-1:0]);
        spec_sign_s = para1[W-1] ^ para2[W-1];
        spec_hit_s  = 1'b1;
        spec_out_s  = FP_QNAN;
        spec_uf_s   = 1'b1;
        if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN)) begin
            spec_out_s = FP_QNAN;
            spec_uf_s  = 1'b1;
        end else if (cls_a_s == CLS_INF) begin
            if (cls_b_s == CLS_INF) begin
                spec_out_s = FP_QNAN;
                spec_uf_s  = 1'b1;
            end else begin
                spec_out_s = {spec_sign_s, FP_POS_INF[W-2:0]};
                spec_uf_s  = 1'b0;
            end
        end else if (cls_a_s == CLS_ZERO) begin
            if (cls_b_s == CLS_ZERO) begin
                spec_out_s = FP_QNAN;
                spec_uf_s  = 1'b1;
            end else begin
                spec_out_s = {spec_sign_s, {(W-1){1'b0}}};
                spec_uf_s  = 1'b0;
            end
        end else if (cls_b_s == CLS_ZERO) begin
            spec_out_s = {spec_sign_s, FP_POS_INF[W-2:0]};
            spec_uf_s  = 1'b1;
        end else if (cls_b_s == CLS_INF) begin
            spec_out_s = {spec_sign_s, {(W-1){1'b0}}};
            spec_uf_s  = 1'b0;
        end else begin
            spec_hit_s = 1'b0;
            spec_out_s = FP_QNAN;
            spec_uf_s  = 1'b0;
        end
    end

    // Special-case result is captured at start and released from SPECIAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_out_q <= {W{1'b0}};
            spec_uf_q  <= 1'b0;
        end else begin
            spec_out_q <= spec_out_d;
            spec_uf_q  <= spec_uf_d;
        end
    end
`endif

    // Next-state and datapath control for the divider FSM.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        uf_d    = uf_q;
        done_d  = 1'b0;
`ifdef FP_DIV_SPECIAL_EN
        spec_out_d = spec_out_q;
        spec_uf_d  = spec_uf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = para1[W-1] ^ para2[W-1];
                    e1_d    = para1[W-2:F_WIDTH];
                    e2_d    = para2[W-2:F_WIDTH];
                    r_d     = {2'b01, para1[F_WIDTH-1:0]};
                    d_d     = {1'b1, para2[F_WIDTH-1:0]};
                    q_d     = {QW{1'b0}};
                    cnt_d   = {CW{1'b0}};
`ifdef FP_DIV_SPECIAL_EN
                    spec_out_d = spec_out_s;
                    spec_uf_d  = spec_uf_s;
                    if (spec_hit_s) begin
                        state_d = ST_SPECIAL;
                    end else begin
                        state_d = ST_DIVIDE;
                    end
`else
                    state_d = ST_DIVIDE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                r_d   = {r_sub_s[RW-2:0], 1'b0};
                q_d   = {q_q[QW-2:0], ge_s};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_DIVIDE;
                end
            end
            ST_NORM: begin
                out_d   = pack_out_s;
                uf_d    = pack_uf_s;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef FP_DIV_SPECIAL_EN
            ST_SPECIAL: begin
                out_d   = spec_out_q;
                uf_d    = spec_uf_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            e1_q    <= {E_WIDTH{1'b0}};
            e2_q    <= {E_WIDTH{1'b0}};
            r_q     <= {RW{1'b0}};
            d_q     <= {DW{1'b0}};
            q_q     <= {QW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            out_q   <= {W{1'b0}};
            uf_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            uf_q    <= uf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign out            = out_q;
    assign under_overflow = uf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed, table-driven bench for fp_div_seq with hand-computed results,
// plus sequences for ignored start, mid-operation reset and back-to-back use.
// Define FP_DIV_SPECIAL_EN to also exercise the special-operand path.
module tb_fp_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] para1;
    logic [31:0] para2;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        under_overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        uf;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    fp_div_seq dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .para1          (para1),
        .para2          (para2),
        .busy           (busy),
        .done           (done),
        .out            (out),
        .under_overflow (under_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation from the current (post-edge) time and wait for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0);
        para1 = a;
        para2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busy0 = busy;
        lat   = -1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (done) lat = n;
        end
    endtask

    initial begin
        int          lat;
        logic        busy0;
        int          ndone;
        int          first;
        logic [31:0] held;

        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 27});
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 27});
        vecs.push_back('{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 27});
        vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 27});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 1'b1, 27});
        vecs.push_back('{32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 1'b0, 27});
        vecs.push_back('{32'h3F800000, 32'hC0800000, 32'hBE800000, 1'b0, 27});
        vecs.push_back('{32'h3F800000, 32'h3F000000, 32'h40000000, 1'b0, 27});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 27});
        vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 27});
        vecs.push_back('{32'h3F7FFFFF, 32'h3F7FFFFE, 32'h3F800001, 1'b0, 27});
`ifdef FP_DIV_SPECIAL_EN
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 1});
        vecs.push_back('{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1});
`endif

        rst   = 1'b1;
        start = 1'b0;
        para1 = 32'h0;
        para2 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out", out, 32'h0);
        check("reset_flags", {29'd0, busy, done, under_overflow}, 32'h0);
        @(posedge clk);
        #1;

        // Table vectors run back to back: each start coincides with the previous done.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, busy0);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_out", i), out, vecs[i].q);
            check($sformatf("v%0d_flag", i), {31'd0, under_overflow}, {31'd0, vecs[i].uf});
            check($sformatf("v%0d_busy_run", i), {31'd0, busy0}, 32'd1);
            check($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
        end

        // done is a single-cycle pulse and the result holds.
        held = out;
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);
        check("out_held", out, held);

        // start during an operation is ignored.
        para1 = 32'h40C00000;
        para2 = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        para1 = 32'h3F800000;
        para2 = 32'h40400000;
        ndone = 0;
        first = -1;
        for (int n = 1; n <= 45; n++) begin
            if (n == 5) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_latency", first, 27);
        check("ignore_out", out, 32'h40400000);

        // Reset in the middle of an operation aborts it.
        para1 = 32'h3F800000;
        para2 = 32'h40400000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out", out, 32'h0);
        check("midrst_flags", {29'd0, busy, done, under_overflow}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_out_after", out, 32'h0);
        check("midrst_busy_after", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential IEEE-754 single-precision divider, computing `out = para1 / para2`. It is the inverse operation to the floating-point multiplier in the ALU. It uses a restoring radix-2 significand divider that produces one quotient bit per clock, then normalizes, rounds and packs the result in a final cycle. A start/done handshake lets the ALU issue an operation and collect the result without stalling its combinational datapath.

## Interface
- `E_WIDTH`, default 8: exponent field width.
- `F_WIDTH`, default 23: fraction field width.
- `E_BIAS`, default 127: exponent bias.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  accept operands; sampled only in IDLE.
- `para1`  in  32  dividend.
- `para2`  in  32  divisor.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse when `out` and `under_overflow` are updated.
- `out`  out  32  result; holds until the next `done`.
- `under_overflow`  out  1  result exponent out of range (or special case, see Configuration); valid with `done`, held with `out`.

## Operation
- States: IDLE, DIVIDE, NORM, plus SPECIAL when the macro is defined.
- IDLE, `start`=1:
  - Latch sign = `para1[31] ^ para2[31]`.
  - Latch E1, E2.
  - Latch R = {1'b0, 1, `para1[22:0]`} (25 bits) and D = {1, `para2[22:0]`}.
  - Clear Q (26 bits) and the counter, then go to DIVIDE.
- DIVIDE, 26 iterations, MSB first:
  - If R >= D: q = 1 and R = R - D; otherwise q = 0.
  - Then R = R << 1 and Q = {Q[24:0], q}.
  - Go to NORM after iteration 26.
- NORM, normalize:
  - If Q[25] = 1: mantissa M = Q[24:2], round bit r = Q[1], adj = 0.
  - If Q[25] = 0: M = Q[23:1], r = Q[0], adj = -1.
- NORM, round half-up:
  - M' = M + r.
  - If the addition carries out of 23 bits: M' = 0 and adj += 1.
- NORM, exponent:
  - E = E1 - E2 + E_BIAS + adj, computed as a 10-bit signed value.
  - If E >= 255: `out` = {sign, 8'hFF, 0} and `under_overflow` = 1.
  - If E <= 0: `out` = {sign, 31'b0} and `under_overflow` = 1.
  - Otherwise: `out` = {sign, E[7:0], M'} and `under_overflow` = 0.
- `start` asserted while `busy` is ignored; the operands are not re-latched.
- Operand changes after the `start` cycle have no effect.

## Timing
- Reset values: `out` = 0, `under_overflow` = 0, `done` = 0, `busy` = 0, state IDLE, counter 0.
- Reset mid-operation aborts immediately and no `done` is produced.
- The edge sampling `start` is edge 0. Edges 1–26 run DIVIDE. Edge 27 is in NORM and registers `out`, `under_overflow` and `done` = 1, and returns to IDLE.
- `done` is high in the cycle after edge 27, i.e. latency 27 clocks. `busy` is high from edge 0 through edge 27.
- `start` may be asserted in the same cycle as `done`, which gives back-to-back operations every 28 cycles.

## Configuration
- `FP_DIV_SPECIAL_EN` defined:
  - In IDLE, classify each operand: exponent 0 means zero; exponent 255 means infinity (fraction 0) or NaN.
  - Special combinations go to SPECIAL and produce `done` after 1 clock (latency 1 clock):
  - NaN operand, 0/0 or inf/inf: `out` = 32'h7FC00000, flag 1.
  - Finite nonzero / 0: signed infinity, flag 1.
  - 0 / nonzero, or finite / inf: signed zero, flag 0.
  - inf / finite: signed infinity, flag 0.
- `FP_DIV_SPECIAL_EN` undefined: every operand is treated as normalized with an implicit 1, and all operations take the 27-cycle path.

## Structure
- Shared package `fp_pkg`:
  - Constants: E_WIDTH, F_WIDTH, E_BIAS.
  - Constants FP_POS_INF = 32'h7F800000 and FP_QNAN = 32'h7FC00000.
  - State enum `fp_div_state_t`.
  - Special-class typedef.
- One combinational sub-module, `fp_round_pack`: normalize select, half-up round, exponent adjust, range check and pack. It is reusable by the multiplier.
- The iteration datapath and FSM stay in `fp_div_seq`.

## Test plan
- 32'h40C00000 / 32'h40000000 (6/2) -> `out` = 32'h40400000, flag 0, `done` exactly 27 clocks after `start`.
- 32'h3F800000 / 32'h40400000 (1/3) -> 32'h3EAAAAAB (normalize path, round up), flag 0.
- 32'hC0C00000 / 32'h40000000 -> 32'hC0400000; then 32'h7F000000 / 32'h3E800000 -> 32'h7F800000, flag 1.
- 32'h00800000 / 32'h40000000 -> 32'h00000000, flag 1 (underflow at E = 0).
- `start` pulsed at cycle 5 during an operation -> ignored, a single `done`; `rst` at cycle 10 -> no `done`, all outputs 0.
- With `FP_DIV_SPECIAL_EN`: 32'h3F800000 / 32'h00000000 -> 32'h7F800000, flag 1, `done` 1 clock after `start`; 0/0 -> 32'h7FC00000.
